// File: rtl/tilemap_writer.sv
// tilemap_writer: host command port (set pointer / write / set step / fill) for the 32x32 tile name RAM.
// Writes only outside active display. Optional command FIFO: define TILEMAP_WRITER_FIFO_EN. Rev 1.0
`default_nettype none

module tilemap_writer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_arg,
  input  logic              video_de,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              busy
);

  localparam logic [1:0] OP_SET_PTR  = 2'd0;
  localparam logic [1:0] OP_WRITE    = 2'd1;
  localparam logic [1:0] OP_SET_STEP = 2'd2;
  localparam logic [1:0] OP_FILL     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WR = 2'd1,
    ST_FILL    = 2'd2
  } state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("tilemap_writer: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] data;
  logic              alive;

  // Command source seen by the engine: either the host directly or the FIFO head.
  logic              take;
  logic [1:0]        src_op;
  logic [ADDR_W-1:0] src_arg;

`ifdef TILEMAP_WRITER_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        op_mem  [FIFO_DEPTH];
  logic [ADDR_W-1:0] arg_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign cmd_ready  = alive && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign take       = (state == ST_IDLE) && !fifo_empty;
  assign src_op     = op_mem[rd_ptr[PW-2:0]];
  assign src_arg    = arg_mem[rd_ptr[PW-2:0]];
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[PW-2:0]]  <= cmd_op;
      arg_mem[wr_ptr[PW-2:0]] <= cmd_arg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (take) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  assign cmd_ready = alive && (state == ST_IDLE);
  assign take      = cmd_valid && cmd_ready;
  assign src_op    = cmd_op;
  assign src_arg   = cmd_arg;
  assign busy      = (state != ST_IDLE);
`endif

  // alive keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      step     <= {{(ADDR_W-1){1'b0}}, 1'b1};
      fill_cnt <= '0;
      data     <= '0;
      alive    <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (take) begin
            case (src_op)
              OP_SET_PTR:  ptr  <= src_arg;
              OP_SET_STEP: step <= src_arg;
              OP_WRITE: begin
                data  <= src_arg[DATA_W-1:0];
                state <= ST_WAIT_WR;
              end
              OP_FILL: begin
                data     <= src_arg[DATA_W-1:0];
                fill_cnt <= '0;
                state    <= ST_FILL;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_WAIT_WR: begin
          if (!video_de) begin
            ptr   <= ptr + step;
            state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (!video_de) begin
            if (fill_cnt == {ADDR_W{1'b1}}) state <= ST_IDLE;
            else                            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // video_de gates the strobe combinationally so no write can land during active display.
  assign ram_we   = ((state == ST_WAIT_WR) || (state == ST_FILL)) && !video_de;
  assign ram_addr = (state == ST_FILL) ? fill_cnt : ptr;
  assign ram_din  = data;

endmodule

`default_nettype wire

// File: tb/tb_tilemap_writer.sv
// tb_tilemap_writer: directed self-checking bench for tilemap_writer.
`default_nettype none

module tb_tilemap_writer;

`ifdef TILEMAP_WRITER_FIFO_EN
  localparam int   LAT      = 2;
  localparam logic RDY_HOLD = 1'b1;
`else
  localparam int   LAT      = 1;
  localparam logic RDY_HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [9:0] cmd_arg;
  logic       video_de;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic       mon_en = 1'b0;
  int         mon_cnt = 0;
  int         mon_bad = 0;
  int         vde_viol = 0;
  logic [9:0] mon_next = '0;
  logic [7:0] mon_din = '0;

  tilemap_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .video_de  (video_de),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && ram_we === 1'b1) begin
      if (video_de !== 1'b0) vde_viol++;
      if (mon_en) begin
        if (ram_addr !== mon_next || ram_din !== mon_din) mon_bad++;
        mon_next++;
        mon_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [1:0] op, input logic [9:0] arg);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    forever begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [9:0] addr, input logic [7:0] din,
                              input int lat);
    repeat (lat) @(negedge clk);
    check({tag, "_we"},   {31'd0, ram_we}, 32'd1);
    check({tag, "_addr"}, {22'd0, ram_addr}, {22'd0, addr});
    check({tag, "_din"},  {24'd0, ram_din}, {24'd0, din});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    logic found;

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; video_de = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_we",    {31'd0, ram_we}, 32'd0);
    check("rst_addr",  {22'd0, ram_addr}, 32'd0);
    check("rst_din",   {24'd0, ram_din}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Pointer wrap at the top of the map
    send(2'd0, 10'h3FF);
    send(2'd2, 10'd1);
    send(2'd1, 10'h007);
    expect_write("wr_3ff", 10'h3FF, 8'h07, LAT);
    @(negedge clk);
    check("after_wr_we",   {31'd0, ram_we}, 32'd0);
    check("after_wr_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    send(2'd1, 10'h005);
    expect_write("wr_wrap", 10'h000, 8'h05, LAT);

    // Column stepping
    send(2'd0, 10'h021);
    send(2'd2, 10'd32);
    send(2'd1, 10'h001);
    expect_write("col0", 10'h021, 8'h01, LAT);
    send(2'd1, 10'h002);
    expect_write("col1", 10'h041, 8'h02, LAT);
    send(2'd1, 10'h003);
    expect_write("col2", 10'h061, 8'h03, LAT);

    // Write held off by active display
    video_de = 1'b1;
    send(2'd1, 10'h0AA);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b0 || busy !== 1'b1 || cmd_ready !== RDY_HOLD) bad++;
    end
    check("de_hold", bad, 0);
    @(posedge clk); #1 video_de = 1'b0;
    expect_write("de_release", 10'h081, 8'hAA, 1);
    if (LAT > 1) begin
      @(negedge clk);
      check("de_release_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end

    // Fill with display toggling 8 high / 8 low
    mon_next = '0; mon_cnt = 0; mon_bad = 0; mon_din = 8'h09; mon_en = 1'b1;
    send(2'd3, 10'h009);
    for (int i = 0; i < 4000; i++) begin
      video_de = (i % 16) >= 8;
      @(negedge clk);
      if (busy !== 1'b1) break;
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    check("fill_count", mon_cnt, 1024);
    check("fill_order", mon_bad, 0);
    check("fill_done",  {31'd0, busy}, 32'd0);
    @(posedge clk); #1 video_de = 1'b0;
    send(2'd1, 10'h011);
    expect_write("fill_ptr_kept", 10'h0A1, 8'h11, LAT);

    // Reset in the middle of a fill
    mon_next = '0; mon_cnt = 0; mon_bad = 0; mon_din = 8'h22; mon_en = 1'b1;
    send(2'd3, 10'h022);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ram_we === 1'b1 && ram_addr === 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    check("fill_reached_300", {31'd0, found}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_we",    {31'd0, ram_we}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_addr",  {22'd0, ram_addr}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("abort_strobes", mon_cnt, 301);
    check("abort_order",   mon_bad, 0);
    check("abort_idle",    {31'd0, busy}, 32'd0);
    check("abort_rdy",     {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    send(2'd1, 10'h033);
    expect_write("reset_ptr", 10'h000, 8'h33, LAT);
    send(2'd1, 10'h044);
    expect_write("reset_step", 10'h001, 8'h44, LAT);

`ifdef TILEMAP_WRITER_FIFO_EN
    // One command is held by the engine and four queue up before the FIFO is full.
    video_de = 1'b1;
    for (int k = 0; k < 5; k++) send(2'd1, 10'h0A0 + 10'(k));
    @(negedge clk);
    check("fifo_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("fifo_full_busy",  {31'd0, busy}, 32'd1);
    check("fifo_full_we",    {31'd0, ram_we}, 32'd0);
    @(posedge clk); #1 video_de = 1'b0;
    for (int k = 0; k < 5; k++)
      expect_write("fifo_drain", 10'd2 + 10'(k), 8'hA0 + 8'(k), (k == 0) ? 1 : 2);
`endif

    check("never_during_de", vde_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
